// File: rtl/double_dabble_sequencer.sv
// rtl/double_dabble_sequencer.sv - FSM sequencing a serial double-dabble binary-to-BCD datapath
// Optional feature macro: DDSEQ_PERF_CNT_EN adds the conv_count completed-conversion counter.

module double_dabble_sequencer #(
    parameter int BIN_W = 8,
    parameter int BCD_W = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_bin,
    output logic             sr_clr,
    output logic             sr_add,
    output logic             sr_en,
    output logic             sr_bit,
    input  logic [BCD_W-1:0] dp_bcd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BCD_W-1:0] out_bcd,
    output logic             busy
`ifdef DDSEQ_PERF_CNT_EN
    ,
    output logic [15:0]      conv_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ADD     = 3'd2,
        S_SHIFT   = 3'd3,
        S_CAPTURE = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               valid_q, valid_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working registers: word being converted (shifted MSB-first), iteration count, result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and register-update logic
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bin_d   = in_bin;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_ADD;
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: begin
                // The current MSB has just been shifted out; move the next bit up
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_ADD;
                end
            end
            S_CAPTURE: begin
                bcd_d   = dp_bcd;
                valid_d = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        in_ready = 1'b0;
        sr_clr   = 1'b0;
        sr_add   = 1'b0;
        sr_en    = 1'b0;
        sr_bit   = 1'b0;
        busy     = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_CLEAR: sr_clr = 1'b1;
            S_ADD:   sr_add = 1'b1;
            S_SHIFT: begin
                sr_en  = 1'b1;
                sr_bit = bin_q[BIN_W-1];
            end
            default: ;
        endcase
    end

    assign out_valid = valid_q;
    assign out_bcd   = bcd_q;

`ifdef DDSEQ_PERF_CNT_EN
    logic [15:0] conv_cnt_q;

    // Completed-conversion counter, advances on each consumed result and wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_cnt_q <= '0;
        end else if (state_q == S_HOLD && out_ready) begin
            conv_cnt_q <= conv_cnt_q + 16'd1;
        end
    end

    assign conv_count = conv_cnt_q;
`endif

endmodule

// File: tb/tb_double_dabble_sequencer.sv
// tb/tb_double_dabble_sequencer.sv - self-checking bench for double_dabble_sequencer with datapath model

module tb_double_dabble_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_bin;
    logic        sr_clr, sr_add, sr_en, sr_bit;
    logic [11:0] dp_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_bcd;
    logic        busy;
`ifdef DDSEQ_PERF_CNT_EN
    logic [15:0] conv_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    double_dabble_sequencer #(.BIN_W(8), .BCD_W(12), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .sr_clr    (sr_clr),
        .sr_add    (sr_add),
        .sr_en     (sr_en),
        .sr_bit    (sr_bit),
        .dp_bcd    (dp_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .busy      (busy)
`ifdef DDSEQ_PERF_CNT_EN
        ,
        .conv_count(conv_count)
`endif
    );

    // Reference double-dabble datapath: 3 BCD digits driven by the strobes
    logic [11:0] dp_q = '0;
    function automatic logic [11:0] add3(input logic [11:0] d);
        logic [11:0] r;
        for (int k = 0; k < 3; k++) begin
            r[4*k +: 4] = (d[4*k +: 4] >= 4'd5) ? d[4*k +: 4] + 4'd3 : d[4*k +: 4];
        end
        return r;
    endfunction
    always_ff @(posedge clk) begin
        if (sr_clr)      dp_q <= '0;
        else if (sr_add) dp_q <= add3(dp_q);
        else if (sr_en)  dp_q <= {dp_q[10:0], sr_bit};
    end
    assign dp_bcd = dp_q;

    function automatic logic [11:0] bcd_of(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_perf();
`ifdef DDSEQ_PERF_CNT_EN
        check("conv_count", conv_count, 32'(n_done[15:0]));
`endif
    endtask

    // One full conversion; hold = cycles out_ready stays low once out_valid is up
    task automatic run(input logic [7:0] val, input int hold);
        int lat, w, n_clr, n_add, n_en, order_err, onehot_err, busy_err, stable_err;
        logic [7:0]  bits;
        logic [11:0] got;
        lat = 0; n_clr = 0; n_add = 0; n_en = 0;
        order_err = 0; onehot_err = 0; busy_err = 0; stable_err = 0;
        bits = '0;
        out_ready = (hold == 0);
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_bin   = val;
        @(posedge clk);
        exp_q.push_back(bcd_of(int'(val)));
        #1;
        in_bin = ~val;
        while (!out_valid && lat < 100) begin
            if (lat == 0) begin
                if (!sr_clr) order_err++;
            end else if (lat < 17 && lat % 2 == 1) begin
                if (!sr_add) order_err++;
            end else if (lat < 17) begin
                if (!sr_en) order_err++;
            end else if (sr_clr || sr_add || sr_en) begin
                order_err++;
            end
            if (int'(sr_clr) + int'(sr_add) + int'(sr_en) > 1) onehot_err++;
            if (!sr_en && sr_bit) onehot_err++;
            if (sr_clr) n_clr++;
            if (sr_add) n_add++;
            if (sr_en) begin
                n_en++;
                bits = {bits[6:0], sr_bit};
            end
            if (in_ready || !busy) busy_err++;
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, 18);
        check("n_clear", n_clr, 1);
        check("n_add", n_add, 8);
        check("n_shift", n_en, 8);
        check("strobe_order", order_err, 0);
        check("strobe_onehot", onehot_err, 0);
        check("busy_no_ready", busy_err, 0);
        check("serial_bits", bits, val);
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("out_bcd", out_bcd, exp_q.pop_front());
        got = out_bcd;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || out_bcd !== got || in_ready) stable_err++;
        end
        check("hold_stable", stable_err, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_done++;
        check("out_valid_dropped", out_valid, 0);
        check("in_ready_after", in_ready, 1);
        out_ready = 1'b0;
        check_perf();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bin = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bcd", out_bcd, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", {sr_clr, sr_add, sr_en, sr_bit}, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check_perf();

        // out_ready with nothing pending does nothing
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_out_ready_valid", out_valid, 0);
        check("idle_out_ready_busy", busy, 0);
        out_ready = 1'b0;
        check_perf();

        run(8'd243, 0);
        run(8'd0, 0);
        run(8'd255, 0);
        run(8'd99, 10);
        run(8'b1000_0001, 0);

        // abort during the 4th shift of 200
        in_valid = 1'b1; in_bin = 8'd200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort_in_shift", sr_en, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_strobes", {sr_clr, sr_add, sr_en, sr_bit}, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_bcd", out_bcd, 0);
        check("abort_in_ready", in_ready, 1);
        n_done = 0;
        check_perf();
        @(negedge clk) rst = 1'b0;

        run(8'd57, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
